student_fir_sample_ctrl: RTL and testbench
==========================================

Name: student_fir_sample_ctrl

Overview:
Sequencer for the FIR sample delay line held in student_dpram_samples: port A writes, port B reads with 1-cycle read latency.
Accepts one input sample per handshake and writes it at the circular write pointer. It then issues TapCount reads, newest sample first, and presents each returned sample as a tap stream to the MAC datapath.
Also zero-fills the RAM after reset and on request.

Parameters:
AddrWidth, 2, RAM address width; depth = 2**AddrWidth
DataSize, 16, sample width in bits
TapCount, 4, taps read per sample; legal range 1..2**AddrWidth (elaboration assertion)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
sample_i  in  DataSize  input sample
sample_valid_i  in  1  sample_i valid
sample_ready_o  out  1  controller accepts sample this cycle
clear_i  in  1  request zero-fill of delay line; sampled in IDLE only
busy_o  out  1  high in CLEAR and READ
tap_data_o  out  DataSize  delayed sample; zero when tap_valid_o low
tap_idx_o  out  AddrWidth  tap index k (0 = newest)
tap_valid_o  out  1  tap_data_o/tap_idx_o valid; no backpressure
tap_last_o  out  1  high with tap k = TapCount-1
ram_ena_o, ram_wea_o  out  1 each  RAM port A enable / write enable
ram_addra_o  out  AddrWidth  RAM write address
ram_dia_o  out  DataSize  RAM write data
ram_enb_o  out  1  RAM port B enable
ram_addrb_o  out  AddrWidth  RAM read address
ram_dob_i  in  DataSize  RAM read data, valid 1 cycle after enb

Behaviour:
- States: CLEAR, IDLE, READ. Registers: wr_ptr, base, k, clr_cnt, read-valid pipeline stage (vld_q, idx_q, last_q).
- Reset (rst_i high): state=CLEAR, wr_ptr=0, clr_cnt=0, k=0, vld_q=0.
- While rst_i is high: all ram_* enables 0, sample_ready_o=0, busy_o=1, tap_valid_o=0, tap_last_o=0, tap_data_o=0, tap_idx_o=0.
- CLEAR:
  - Each cycle drive ena=wea=1, addra=clr_cnt, dia=0, then clr_cnt++.
  - After writing address depth-1: go IDLE, wr_ptr=0.
  - Takes exactly 2**AddrWidth cycles.
- IDLE:
  - sample_ready_o = !clear_i.
  - clear_i=1: go CLEAR with clr_cnt=0; a simultaneous sample is not accepted.
  - Handshake (valid & ready): same cycle drive ena=wea=1, addra=wr_ptr, dia=sample_i; base<=wr_ptr; wr_ptr<=wr_ptr+1 (mod depth); k<=0; go READ.
- READ:
  - Each cycle drive enb=1, addrb=base-k (mod depth); vld_q<=1, idx_q<=k, last_q<=(k==TapCount-1).
  - k==TapCount-1: go IDLE; otherwise k++.
  - sample_ready_o=0; clear_i ignored.
- Tap output:
  - tap_valid_o=vld_q, tap_idx_o=idx_q, tap_last_o=vld_q&last_q, tap_data_o = vld_q ? ram_dob_i : 0.
  - vld_q clears in any cycle with no read issued.
- Latency: handshake at cycle t → tap 0 at t+2, last tap at t+1+TapCount.
- Throughput: one sample per TapCount+1 cycles. The next handshake may coincide with the last tap output.
- Write/read ordering: the written address is read no earlier than the following cycle, so there is no same-address collision. With TapCount=depth, the oldest read (base+1) completes before the next write to base+1.
- Wrap-around: all pointer arithmetic is modulo 2**AddrWidth.
- Reset mid-READ or mid-CLEAR: abort immediately, no further taps, full CLEAR restarts after release.

Decomposition:
- Package student_fir_pkg: typedef enum logic [1:0] {CLEAR, IDLE, READ} sample_ctrl_state_e.
- No sub-module. The DPRAM is instantiated by the parent next to this block; the bench instantiates student_dpram_samples with DebugMode=1 and a zeros init file.

Test Plan:
1. Release rst_i → exactly 4 cycles of ena=wea=1, addra 0,1,2,3, dia=0; sample_ready_o low during those cycles, high on the 5th.
2. Push 0x0011 → write addra=0; reads addrb 0,3,2,1; taps 0x0011,0,0,0 with idx 0..3; tap0 two cycles after handshake; tap_last_o only on idx 3.
3. Hold sample_valid_i with 0x0022,0x0033,0x0044,0x0055 back-to-back (wr_ptr wraps) → one accept every 5 cycles; after 0x0055 (written at addr 0), taps are 0x0055,0x0044,0x0033,0x0022.
4. clear_i=1 with sample_valid_i=1 in IDLE → no accept, 4 zero writes, wr_ptr=0; next sample 0x00AA → taps 0x00AA,0,0,0.
5. Assert rst_i during READ at k=2 → no taps in following cycles, tap_valid_o=0, CLEAR sequence restarts after release.
6. TapCount=3 variant → 3 taps per sample, tap_last_o on idx 2, one accept every 4 cycles.

Source files
------------

// File: rtl/student_fir_pkg.sv
// Shared types for the FIR sample delay-line controller.
package student_fir_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    READ  = 2'd2
  } sample_ctrl_state_e;

endpackage

// File: rtl/student_fir_sample_ctrl.sv
// Delay-line sequencer: zero-fills the sample RAM, writes each accepted sample at the
// circular write pointer, then streams TapCount delayed samples (newest first) to the MAC.
module student_fir_sample_ctrl
  import student_fir_pkg::*;
#(
  parameter int AddrWidth = 2,
  parameter int DataSize  = 16,
  parameter int TapCount  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataSize-1:0]  sample_i,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic [DataSize-1:0]  tap_data_o,
  output logic [AddrWidth-1:0] tap_idx_o,
  output logic                 tap_valid_o,
  output logic                 tap_last_o,
  output logic                 ram_ena_o,
  output logic                 ram_wea_o,
  output logic [AddrWidth-1:0] ram_addra_o,
  output logic [DataSize-1:0]  ram_dia_o,
  output logic                 ram_enb_o,
  output logic [AddrWidth-1:0] ram_addrb_o,
  input  logic [DataSize-1:0]  ram_dob_i
);

  localparam logic [AddrWidth-1:0] LastTap  = AddrWidth'(TapCount - 1);
  localparam logic [AddrWidth-1:0] LastAddr = '1;

  if (TapCount < 1 || TapCount > (1 << AddrWidth)) begin : g_tapcount_check
    $error("student_fir_sample_ctrl: TapCount must be within 1..2**AddrWidth");
  end

  sample_ctrl_state_e    r_state;
  sample_ctrl_state_e    w_state_nxt;
  logic [AddrWidth-1:0]  r_wr_ptr;
  logic [AddrWidth-1:0]  r_base;
  logic [AddrWidth-1:0]  r_k;
  logic [AddrWidth-1:0]  r_clr_cnt;
  logic                  r_vld_q;
  logic [AddrWidth-1:0]  r_idx_q;
  logic                  r_last_q;
  logic                  w_accept;

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    sample_ready_o = 1'b0;
    busy_o         = 1'b0;
    ram_ena_o      = 1'b0;
    ram_wea_o      = 1'b0;
    ram_addra_o    = '0;
    ram_dia_o      = '0;
    ram_enb_o      = 1'b0;
    ram_addrb_o    = '0;
    if (rst_i) begin
      busy_o = 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          busy_o      = 1'b1;
          ram_ena_o   = 1'b1;
          ram_wea_o   = 1'b1;
          ram_addra_o = r_clr_cnt;
          if (r_clr_cnt == LastAddr) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = CLEAR;
          end
        end
        IDLE: begin
          sample_ready_o = !clear_i;
          if (clear_i) begin
            w_state_nxt = CLEAR;
          end else if (sample_valid_i) begin
            w_accept    = 1'b1;
            ram_ena_o   = 1'b1;
            ram_wea_o   = 1'b1;
            ram_addra_o = r_wr_ptr;
            ram_dia_o   = sample_i;
            w_state_nxt = READ;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        READ: begin
          busy_o      = 1'b1;
          ram_enb_o   = 1'b1;
          ram_addrb_o = r_base - r_k;
          if (r_k == LastTap) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = READ;
          end
        end
        default: begin
          w_state_nxt = CLEAR;
        end
      endcase
    end
  end

  // The read-valid stage mirrors the RAM's one-cycle read latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= CLEAR;
      r_wr_ptr  <= '0;
      r_base    <= '0;
      r_k       <= '0;
      r_clr_cnt <= '0;
      r_vld_q   <= 1'b0;
      r_idx_q   <= '0;
      r_last_q  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vld_q  <= (r_state == READ);
      r_idx_q  <= (r_state == READ) ? r_k : '0;
      r_last_q <= (r_state == READ) && (r_k == LastTap);
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LastAddr) begin
            r_wr_ptr <= '0;
          end
        end
        IDLE: begin
          if (clear_i) begin
            r_clr_cnt <= '0;
          end else if (w_accept) begin
            r_base   <= r_wr_ptr;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_k      <= '0;
          end
        end
        READ: begin
          if (r_k != LastTap) begin
            r_k <= r_k + 1'b1;
          end
        end
        default: begin
          r_clr_cnt <= '0;
        end
      endcase
    end
  end

  assign tap_valid_o = !rst_i && r_vld_q;
  assign tap_idx_o   = rst_i ? '0 : r_idx_q;
  assign tap_last_o  = !rst_i && r_vld_q && r_last_q;
  assign tap_data_o  = (!rst_i && r_vld_q) ? ram_dob_i : '0;

endmodule

// File: tb/tb_student_fir_sample_ctrl.sv
// Directed bench for student_fir_sample_ctrl: a default (TapCount=4) instance and a
// TapCount=3 instance, each backed by a small behavioural dual-port RAM.
module tb_student_fir_sample_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic preset;
  int   checks;
  int   failures;

  logic [15:0] a_sample, a_tap_data, a_dia, a_dob;
  logic        a_valid, a_ready, a_clear, a_busy, a_tap_valid, a_tap_last;
  logic        a_ena, a_wea, a_enb;
  logic [1:0]  a_tap_idx, a_addra, a_addrb;

  logic [15:0] b_sample, b_tap_data, b_dia, b_dob;
  logic        b_valid, b_ready, b_clear, b_busy, b_tap_valid, b_tap_last;
  logic        b_ena, b_wea, b_enb;
  logic [1:0]  b_tap_idx, b_addra, b_addrb;

  logic [15:0] mem_a [4];
  logic [15:0] mem_b [4];

  student_fir_sample_ctrl #(.AddrWidth(2), .DataSize(16), .TapCount(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .sample_i(a_sample), .sample_valid_i(a_valid),
    .sample_ready_o(a_ready), .clear_i(a_clear), .busy_o(a_busy),
    .tap_data_o(a_tap_data), .tap_idx_o(a_tap_idx), .tap_valid_o(a_tap_valid),
    .tap_last_o(a_tap_last), .ram_ena_o(a_ena), .ram_wea_o(a_wea),
    .ram_addra_o(a_addra), .ram_dia_o(a_dia), .ram_enb_o(a_enb),
    .ram_addrb_o(a_addrb), .ram_dob_i(a_dob)
  );

  student_fir_sample_ctrl #(.AddrWidth(2), .DataSize(16), .TapCount(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .sample_i(b_sample), .sample_valid_i(b_valid),
    .sample_ready_o(b_ready), .clear_i(b_clear), .busy_o(b_busy),
    .tap_data_o(b_tap_data), .tap_idx_o(b_tap_idx), .tap_valid_o(b_tap_valid),
    .tap_last_o(b_tap_last), .ram_ena_o(b_ena), .ram_wea_o(b_wea),
    .ram_addra_o(b_addra), .ram_dia_o(b_dia), .ram_enb_o(b_enb),
    .ram_addrb_o(b_addrb), .ram_dob_i(b_dob)
  );

  // Garbage preset makes the zero-fill observable through later reads.
  always @(posedge clk) begin
    if (preset) begin
      for (int m = 0; m < 4; m++) begin
        mem_a[m] <= 16'hDEAD;
        mem_b[m] <= 16'hBEEF;
      end
    end else begin
      if (a_ena && a_wea) mem_a[a_addra] <= a_dia;
      if (b_ena && b_wea) mem_b[b_addra] <= b_dia;
    end
    if (a_enb) a_dob <= mem_a[a_addrb];
    if (b_enb) b_dob <= mem_b[b_addrb];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    preset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({a_ena, a_enb, a_ready, a_busy, a_tap_valid, a_tap_last} !== 6'b000100 ||
        a_tap_data !== 16'h0 || a_tap_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs got ena=%0b enb=%0b rdy=%0b busy=%0b tv=%0b tl=%0b td=%h ti=%0d exp 0,0,0,1,0,0,0000,0",
               a_ena, a_enb, a_ready, a_busy, a_tap_valid, a_tap_last, a_tap_data, a_tap_idx);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({a_ena, a_wea, a_addra, a_dia, a_ready, a_busy} !== {1'b1, 1'b1, 2'(i), 16'h0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL clear_write%0d got ena=%0b wea=%0b addra=%0d dia=%h rdy=%0b busy=%0b exp 1,1,%0d,0000,0,1",
                 i, a_ena, a_wea, a_addra, a_dia, a_ready, a_busy, i);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_ena !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_clear got rdy=%0b busy=%0b ena=%0b exp 1,0,0", a_ready, a_busy, a_ena);
    end
    tick();
  endtask

  task automatic test_single();
    logic [15:0] exp_tap [4] = '{16'h0011, 16'h0000, 16'h0000, 16'h0000};
    logic [1:0]  exp_rd  [4] = '{2'd0, 2'd3, 2'd2, 2'd1};
    a_sample = 16'h0011;
    a_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, a_ena, a_wea, a_addra, a_dia} !== {1'b1, 1'b1, 1'b1, 2'd0, 16'h0011}) begin
      failures++;
      $display("FAIL single_write got rdy=%0b ena=%0b wea=%0b addra=%0d dia=%h exp 1,1,1,0,0011",
               a_ready, a_ena, a_wea, a_addra, a_dia);
    end
    tick();
    a_valid = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      checks++;
      if (j <= 4) begin
        if (a_enb !== 1'b1 || a_addrb !== exp_rd[j-1] || a_ready !== 1'b0) begin
          failures++;
          $display("FAIL single_read%0d got enb=%0b addrb=%0d rdy=%0b exp 1,%0d,0", j, a_enb, a_addrb, a_ready, exp_rd[j-1]);
        end
      end else if (a_enb !== 1'b0) begin
        failures++;
        $display("FAIL single_noread%0d got enb=%0b exp 0", j, a_enb);
      end
      checks++;
      if (j >= 2 && j <= 5) begin
        if ({a_tap_valid, a_tap_idx, a_tap_data, a_tap_last} !== {1'b1, 2'(j-2), exp_tap[j-2], (j == 5)}) begin
          failures++;
          $display("FAIL single_tap%0d got tv=%0b ti=%0d td=%h tl=%0b exp 1,%0d,%h,%0b",
                   j-2, a_tap_valid, a_tap_idx, a_tap_data, a_tap_last, j-2, exp_tap[j-2], (j == 5));
        end
      end else if (a_tap_valid !== 1'b0 || a_tap_data !== 16'h0 || a_tap_last !== 1'b0) begin
        failures++;
        $display("FAIL single_notap_cyc%0d got tv=%0b td=%h tl=%0b exp 0,0000,0", j, a_tap_valid, a_tap_data, a_tap_last);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] smp [4] = '{16'h0022, 16'h0033, 16'h0044, 16'h0055};
    logic [1:0]  wa  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] exp_tap [4][4] = '{'{16'h0022, 16'h0011, 16'h0000, 16'h0000},
                                    '{16'h0033, 16'h0022, 16'h0011, 16'h0000},
                                    '{16'h0044, 16'h0033, 16'h0022, 16'h0011},
                                    '{16'h0055, 16'h0044, 16'h0033, 16'h0022}};
    for (int n = 0; n < 4; n++) begin
      a_sample = smp[n];
      a_valid  = 1'b1;
      for (int j = 0; j < 5; j++) begin
        logic        has_tap;
        int          idx;
        logic [15:0] exp_d;
        @(negedge clk);
        checks++;
        if (j == 0) begin
          if ({a_ready, a_ena, a_wea, a_addra, a_dia} !== {1'b1, 1'b1, 1'b1, wa[n], smp[n]}) begin
            failures++;
            $display("FAIL b2b_accept%0d got rdy=%0b ena=%0b addra=%0d dia=%h exp 1,1,%0d,%h",
                     n, a_ready, a_ena, a_addra, a_dia, wa[n], smp[n]);
          end
        end else if (a_ready !== 1'b0 || a_ena !== 1'b0) begin
          failures++;
          $display("FAIL b2b_hold%0d_%0d got rdy=%0b ena=%0b exp 0,0", n, j, a_ready, a_ena);
        end
        has_tap = (j >= 2) || (j == 0 && n > 0);
        idx     = (j >= 2) ? j - 2 : 3;
        exp_d   = 16'h0;
        if (j >= 2) exp_d = exp_tap[n][j-2];
        else if (n > 0) exp_d = exp_tap[n-1][3];
        checks++;
        if (has_tap) begin
          if ({a_tap_valid, a_tap_idx, a_tap_data, a_tap_last} !== {1'b1, 2'(idx), exp_d, (idx == 3)}) begin
            failures++;
            $display("FAIL b2b_tap%0d_%0d got tv=%0b ti=%0d td=%h tl=%0b exp 1,%0d,%h,%0b",
                     n, j, a_tap_valid, a_tap_idx, a_tap_data, a_tap_last, idx, exp_d, (idx == 3));
          end
        end else if (a_tap_valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b_notap%0d_%0d got tv=%0b exp 0", n, j, a_tap_valid);
        end
        tick();
      end
    end
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_tap_valid, a_tap_idx, a_tap_data, a_tap_last, a_ready} !== {1'b1, 2'd3, 16'h0022, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL b2b_final_tap got tv=%0b ti=%0d td=%h tl=%0b rdy=%0b exp 1,3,0022,1,1",
               a_tap_valid, a_tap_idx, a_tap_data, a_tap_last, a_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_tap_valid !== 1'b0 || a_tap_last !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got tv=%0b tl=%0b exp 0,0", a_tap_valid, a_tap_last);
    end
    tick();
  endtask

  task automatic test_clear();
    logic [15:0] exp_tap [4] = '{16'h00AA, 16'h0000, 16'h0000, 16'h0000};
    a_clear  = 1'b1;
    a_valid  = 1'b1;
    a_sample = 16'h00BB;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || a_ena !== 1'b0) begin
      failures++;
      $display("FAIL clear_blocks_accept got rdy=%0b ena=%0b exp 0,0", a_ready, a_ena);
    end
    tick();
    a_clear = 1'b0;
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({a_ena, a_wea, a_addra, a_dia, a_ready, a_busy} !== {1'b1, 1'b1, 2'(i), 16'h0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL req_clear_write%0d got ena=%0b wea=%0b addra=%0d dia=%h rdy=%0b busy=%0b exp 1,1,%0d,0000,0,1",
                 i, a_ena, a_wea, a_addra, a_dia, a_ready, a_busy, i);
      end
      tick();
    end
    a_sample = 16'h00AA;
    a_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, a_ena, a_addra, a_dia} !== {1'b1, 1'b1, 2'd0, 16'h00AA}) begin
      failures++;
      $display("FAIL clear_wrptr got rdy=%0b ena=%0b addra=%0d dia=%h exp 1,1,0,00aa", a_ready, a_ena, a_addra, a_dia);
    end
    tick();
    a_valid = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        checks++;
        if ({a_tap_valid, a_tap_idx, a_tap_data, a_tap_last} !== {1'b1, 2'(j-2), exp_tap[j-2], (j == 5)}) begin
          failures++;
          $display("FAIL clear_tap%0d got tv=%0b ti=%0d td=%h tl=%0b exp 1,%0d,%h,%0b",
                   j-2, a_tap_valid, a_tap_idx, a_tap_data, a_tap_last, j-2, exp_tap[j-2], (j == 5));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    a_sample = 16'h0077;
    a_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ena !== 1'b1 || a_addra !== 2'd1) begin
      failures++;
      $display("FAIL mid_accept got ena=%0b addra=%0d exp 1,1", a_ena, a_addra);
    end
    tick();
    a_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({a_tap_valid, a_tap_data, a_addrb} !== {1'b1, 16'h0077, 2'd0}) begin
      failures++;
      $display("FAIL mid_tap0 got tv=%0b td=%h addrb=%0d exp 1,0077,0", a_tap_valid, a_tap_data, a_addrb);
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({a_tap_valid, a_enb, a_ena, a_ready, a_busy, a_tap_last} !== 6'b000010 || a_tap_data !== 16'h0) begin
        failures++;
        $display("FAIL mid_reset%0d got tv=%0b enb=%0b ena=%0b rdy=%0b busy=%0b tl=%0b td=%h exp 0,0,0,0,1,0,0000",
                 c, a_tap_valid, a_enb, a_ena, a_ready, a_busy, a_tap_last, a_tap_data);
      end
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({a_ena, a_wea, a_addra, a_tap_valid, a_enb} !== {1'b1, 1'b1, 2'(i), 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL mid_reclear%0d got ena=%0b wea=%0b addra=%0d tv=%0b enb=%0b exp 1,1,%0d,0,0",
                 i, a_ena, a_wea, a_addra, a_tap_valid, a_enb, i);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_tap_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_idle got rdy=%0b tv=%0b exp 1,0", a_ready, a_tap_valid);
    end
    tick();
  endtask

  task automatic test_tapcount3();
    logic [15:0] smp [2] = '{16'h0101, 16'h0202};
    logic [1:0]  wa  [2] = '{2'd0, 2'd1};
    logic [1:0]  rd  [2][3] = '{'{2'd0, 2'd3, 2'd2}, '{2'd1, 2'd0, 2'd3}};
    logic [15:0] exp_tap [2][3] = '{'{16'h0101, 16'h0000, 16'h0000},
                                    '{16'h0202, 16'h0101, 16'h0000}};
    for (int n = 0; n < 2; n++) begin
      b_sample = smp[n];
      b_valid  = 1'b1;
      for (int j = 0; j < 4; j++) begin
        logic        has_tap;
        int          idx;
        logic [15:0] exp_d;
        @(negedge clk);
        checks++;
        if (j == 0) begin
          if ({b_ready, b_ena, b_addra, b_dia} !== {1'b1, 1'b1, wa[n], smp[n]}) begin
            failures++;
            $display("FAIL tc3_accept%0d got rdy=%0b ena=%0b addra=%0d dia=%h exp 1,1,%0d,%h",
                     n, b_ready, b_ena, b_addra, b_dia, wa[n], smp[n]);
          end
        end else if ({b_ready, b_enb, b_addrb, b_busy} !== {1'b0, 1'b1, rd[n][j-1], 1'b1}) begin
          failures++;
          $display("FAIL tc3_read%0d_%0d got rdy=%0b enb=%0b addrb=%0d busy=%0b exp 0,1,%0d,1",
                   n, j, b_ready, b_enb, b_addrb, b_busy, rd[n][j-1]);
        end
        has_tap = (j >= 2) || (j == 0 && n > 0);
        idx     = (j >= 2) ? j - 2 : 2;
        exp_d   = 16'h0;
        if (j >= 2) exp_d = exp_tap[n][j-2];
        else if (n > 0) exp_d = exp_tap[n-1][2];
        checks++;
        if (has_tap) begin
          if ({b_tap_valid, b_tap_idx, b_tap_data, b_tap_last} !== {1'b1, 2'(idx), exp_d, (idx == 2)}) begin
            failures++;
            $display("FAIL tc3_tap%0d_%0d got tv=%0b ti=%0d td=%h tl=%0b exp 1,%0d,%h,%0b",
                     n, j, b_tap_valid, b_tap_idx, b_tap_data, b_tap_last, idx, exp_d, (idx == 2));
          end
        end else if (b_tap_valid !== 1'b0) begin
          failures++;
          $display("FAIL tc3_notap%0d_%0d got tv=%0b exp 0", n, j, b_tap_valid);
        end
        tick();
      end
    end
    b_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_tap_valid, b_tap_idx, b_tap_data, b_tap_last, b_ready} !== {1'b1, 2'd2, 16'h0000, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL tc3_final_tap got tv=%0b ti=%0d td=%h tl=%0b rdy=%0b exp 1,2,0000,1,1",
               b_tap_valid, b_tap_idx, b_tap_data, b_tap_last, b_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (b_tap_valid !== 1'b0 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL tc3_drain got tv=%0b busy=%0b exp 0,0", b_tap_valid, b_busy);
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    preset   = 1'b1;
    a_sample = 16'h0;
    a_valid  = 1'b0;
    a_clear  = 1'b0;
    b_sample = 16'h0;
    b_valid  = 1'b0;
    b_clear  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_reset_mid_read();
    test_tapcount3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
